instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
//   IF stage of the pipelined CPU. Owns the program counter and drives it into the
//   combinational instruction ROM, whose 9-bit instruction returns the same cycle.
//   Registers {instruction, pc, valid} into the IF/ID pipeline register for decode.
//   Handles stall, branch/jump redirect with flush, and halt detection.
// PARAMETERS
//   PC_W      16         program counter width
//   INSTR_W   9          instruction width ({opcode[8:4], operand[3:0]})
//   OP_W      5          opcode width (instr[INSTR_W-1 -: OP_W])
//   RESET_PC  16'd1      first fetch address (program image starts at 1)
//   HALT_OP   5'b11010   halt opcode
// PORTS
//   clk            in   1        rising-edge clock
//   rst_n          in   1        asynchronous active-low reset
//   stall          in   1        hazard unit: hold PC and IF/ID this cycle
//   redirect       in   1        branch taken / jump resolved downstream
//   redirect_pc    in   PC_W     target address for redirect
//   rom_instr      in   INSTR_W  instruction returned by ROM for rom_pc
//   rom_pc         out  PC_W     current PC driven to ROM (= pc register)
//   if_id_instr    out  INSTR_W  registered instruction to decode
//   if_id_pc       out  PC_W     PC of if_id_instr
//   if_id_valid    out  1        IF/ID holds a real instruction (0 = bubble)
//   halted         out  1        halt was fetched and accepted; fetch frozen
//   fetch_count    out  16       instructions accepted into IF/ID, saturating
// BEHAVIOUR
//   Reset (async, rst_n=0): pc=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_valid=0,
//     halted=0, fetch_count=0, state=RUN. Release is synchronous to the next clk edge.
//   rom_pc = pc, combinational. The ROM has zero latency, so rom_instr is sampled
//     in the same cycle the PC is presented.
//   State machine:
//     RUN:    normal fetch.
//     HALTED: terminal; left only by reset.
//   RUN, per-edge priority redirect > stall > accept:
//     redirect=1: pc<=redirect_pc; if_id_valid<=0; if_id_instr<=0; if_id_pc<=0.
//       The instruction currently fetched is discarded and not counted.
//       Redirect overrides stall in the same cycle.
//       A halt fetched in the same cycle is squashed; the state stays RUN.
//     stall=1 (no redirect): pc, if_id_* and fetch_count hold.
//       A halt at rom_instr is not acted on until it is accepted.
//     accept: if_id_instr<=rom_instr; if_id_pc<=pc; if_id_valid<=1;
//       fetch_count<=fetch_count+1, saturating at 16'hFFFF.
//       If rom_instr[8:4]==HALT_OP: pc holds, state<=HALTED, halted<=1.
//       Otherwise pc<=pc+1, mod 2^PC_W (16'hFFFF wraps to 0).
//   HALTED:
//     pc frozen at the halt's address.
//     The IF/ID register holds the halt with valid=1 for one accept cycle; on the
//       following edge, if_id_valid<=0 and it stays 0.
//     If stall=1 on that edge, the halt is held in IF/ID until stall drops.
//     redirect is ignored; fetch_count is frozen.
//   The halt instruction itself is passed to decode so that downstream stages drain.
//   No combinational path exists from stall or redirect to rom_pc.
//   Reset asserted mid-operation clears all state immediately, including HALTED.
// TESTING
//   1 Reset, then ROM returns {5'b00110,4'b0001} at pc=1 and a ramp after that:
//       -> rom_pc 1,2,3...; if_id_pc 1,2,3 one cycle behind; valid=1; fetch_count counts.
//   2 stall=1 for 3 cycles at pc=5:
//       -> rom_pc stays 5; IF/ID keeps pc=4; fetch_count unchanged;
//       -> after release, if_id_pc=5 on the next edge.
//   3 redirect=1, redirect_pc=16'h000A, stall=1 in the same cycle at pc=7:
//       -> next cycle rom_pc=10, if_id_valid=0;
//       -> following cycle if_id_pc=10, valid=1.
//   4 ROM returns {5'b11010,4'b0000} at pc=15:
//       -> if_id_instr=9'h1A0, if_id_pc=15, valid=1, halted=1, rom_pc stays 15;
//       -> next cycle valid=0; a later redirect is ignored.
//   5 halt at rom_instr with redirect=1 the same cycle:
//       -> halted stays 0, pc<=redirect_pc.
//   6 pc forced to 16'hFFFF via redirect, then accept:
//       -> rom_pc=0.
//   6b rst_n pulsed low mid-HALTED:
//       -> all outputs go to reset values asynchronously; rom_pc=1.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, presents it to the zero-latency instruction ROM and
// registers {instruction, pc, valid} into IF/ID, with stall, redirect/flush and halt handling.
module instruction_fetch_stage #(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned INSTR_W  = 9,
  parameter int unsigned OP_W     = 5,
  parameter logic [PC_W-1:0] RESET_PC = 16'd1,
  parameter logic [OP_W-1:0] HALT_OP  = 5'b11010
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic [INSTR_W-1:0] rom_instr,
  output logic [PC_W-1:0]    rom_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic [PC_W-1:0]    if_id_pc_q, if_id_pc_d;
  logic               if_id_valid_q, if_id_valid_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;

  logic is_halt_c;
  logic flush_c;
  logic accept_c;
  logic drain_c;

  assign is_halt_c = (rom_instr[INSTR_W-1 -: OP_W] == HALT_OP);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a halt moves to HALTED only once it is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (!redirect && !stall && is_halt_c) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // FSM outputs: per-edge action selects for the datapath
  always_comb begin
    flush_c  = 1'b0;
    accept_c = 1'b0;
    drain_c  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect)    flush_c  = 1'b1;
        else if (!stall) accept_c = 1'b1;
      end
      ST_HALTED: drain_c = !stall;
      default: ;
    endcase
  end

  // Datapath next state; everything holds unless an action applies
  always_comb begin
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;
    if (flush_c) begin
      pc_d          = redirect_pc;
      if_id_instr_d = '0;
      if_id_pc_d    = '0;
      if_id_valid_d = 1'b0;
    end else if (accept_c) begin
      if_id_instr_d = rom_instr;
      if_id_pc_d    = pc_q;
      if_id_valid_d = 1'b1;
      if (fetch_count_q != {CNT_W{1'b1}}) fetch_count_d = fetch_count_q + CNT_W'(1);
      if (is_halt_c) halted_d = 1'b1;
      else           pc_d     = pc_q + PC_W'(1);
    end else if (drain_c) begin
      if_id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      if_id_instr_q <= '0;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign rom_pc      = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_valid = if_id_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a small behavioural ROM.
module tb_instruction_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [8:0]  rom_instr;
  logic [15:0] rom_pc;
  logic [8:0]  if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic        halt_en;
  logic [15:0] halt_pc;

  int n_checks;
  int n_pass;

  instruction_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .rom_instr   (rom_instr),
    .rom_pc      (rom_pc),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // ROM: 0x061 at address 1, optional halt at halt_pc, otherwise {00001, pc[3:0]}
  always_comb begin
    if (rom_pc == 16'd1)                   rom_instr = 9'h061;
    else if (halt_en && rom_pc == halt_pc) rom_instr = 9'h1A0;
    else                                   rom_instr = {5'b00001, rom_pc[3:0]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input int pc_exp, input int ifpc_exp,
                          input int valid_exp, input int cnt_exp);
    check_eq({tag, ".rom_pc"},      32'(rom_pc),      32'(pc_exp));
    check_eq({tag, ".if_id_pc"},    32'(if_id_pc),    32'(ifpc_exp));
    check_eq({tag, ".if_id_valid"}, 32'(if_id_valid), 32'(valid_exp));
    check_eq({tag, ".fetch_count"}, 32'(fetch_count), 32'(cnt_exp));
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'd0;
    halt_en = 1'b0; halt_pc = 16'd0;
    n_checks = 0; n_pass = 0;

    // Reset values
    step(); step();
    check_if("reset", 1, 0, 0, 0);
    check_eq("reset.instr",  32'(if_id_instr), 0);
    check_eq("reset.halted", 32'(halted), 0);
    rst_n = 1'b1;

    // Sequential fetch
    step();
    check_if("seq1", 2, 1, 1, 1);
    check_eq("seq1.instr", 32'(if_id_instr), 32'h061);
    step(); check_if("seq2", 3, 2, 1, 2);
    step(); check_if("seq3", 4, 3, 1, 3);
    check_eq("seq3.instr", 32'(if_id_instr), 32'h013);
    step(); check_if("seq4", 5, 4, 1, 4);

    // Stall holds PC, IF/ID and count
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_if("stall", 5, 4, 1, 4);
    end
    stall = 1'b0;
    step(); check_if("unstall1", 6, 5, 1, 5);
    step(); check_if("unstall2", 7, 6, 1, 6);

    // Redirect beats stall and flushes
    redirect = 1'b1; redirect_pc = 16'h000A; stall = 1'b1;
    step(); check_if("redir", 10, 0, 0, 6);
    check_eq("redir.instr", 32'(if_id_instr), 0);
    redirect = 1'b0; stall = 1'b0;
    step(); check_if("redir_acc", 11, 10, 1, 7);
    check_eq("redir_acc.instr", 32'(if_id_instr), 32'h01A);

    // Halt squashed by a same-cycle redirect
    halt_en = 1'b1; halt_pc = 16'd12;
    step(); check_if("pre_sq", 12, 11, 1, 8);
    redirect = 1'b1; redirect_pc = 16'd14;
    step(); check_if("squash", 14, 0, 0, 8);
    check_eq("squash.halted", 32'(halted), 0);

    // PC wrap at 0xFFFF
    redirect_pc = 16'hFFFF;
    step(); check_if("to_ffff", 32'hFFFF, 0, 0, 8);
    redirect = 1'b0;
    step(); check_if("wrap", 0, 32'hFFFF, 1, 9);
    step(); check_if("wrap2", 1, 0, 1, 10);

    // Halt: stalled first, then accepted
    halt_pc = 16'd15; redirect = 1'b1; redirect_pc = 16'd14;
    step(); check_if("to14", 14, 0, 0, 10);
    redirect = 1'b0;
    step(); check_if("at15", 15, 14, 1, 11);
    stall = 1'b1;
    step(); check_if("halt_stall", 15, 14, 1, 11);
    check_eq("halt_stall.halted", 32'(halted), 0);
    stall = 1'b0;
    step(); check_if("halt_acc", 15, 15, 1, 12);
    check_eq("halt_acc.instr",  32'(if_id_instr), 32'h1A0);
    check_eq("halt_acc.halted", 32'(halted), 1);
    stall = 1'b1;
    step(); check_if("halt_hold", 15, 15, 1, 12);
    check_eq("halt_hold.instr", 32'(if_id_instr), 32'h1A0);
    stall = 1'b0; redirect = 1'b1; redirect_pc = 16'd3;
    step(); check_if("halt_drain", 15, 15, 0, 12);
    check_eq("halt_drain.halted", 32'(halted), 1);
    step(); check_if("halt_frozen", 15, 15, 0, 12);
    redirect = 1'b0;

    // Asynchronous reset while halted
    rst_n = 1'b0;
    #2;
    check_if("async_rst", 1, 0, 0, 0);
    check_eq("async_rst.halted", 32'(halted), 0);
    check_eq("async_rst.instr",  32'(if_id_instr), 0);
    halt_en = 1'b0;
    #4;
    rst_n = 1'b1;
    step(); check_if("post_rst", 2, 1, 1, 1);
    check_eq("post_rst.halted", 32'(halted), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
